mux_arb: RTL and testbench

Parametrised, registered N-input successor to the 16-bit 2:1 datapath mux. Selects one of `NUM_IN` valid/ready sources onto a single registered output using round-robin arbitration. Supports multi-beat bursts: a grant is held until the source's `in_last` beat transfers. Intended first use: sharing the LC-3b memory port between instruction fetch, data access and future DMA/IO masters.

---
 rtl/lc3b_pkg.sv | 11 +
 rtl/mux_arb_rr_pick.sv | 31 +++
 rtl/mux_arb.sv | 111 +++++++++++
 tb/tb_mux_arb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions: the machine word width and the arbiter state encoding.
package lc3b_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after ptr, wrapping at NUM_IN-1.
module rr_pick #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            if (req[cand]) begin
                found = 1'b1;
                idx   = SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// Registered N:1 valid/ready mux with round-robin arbitration; a grant is held until its in_last beat transfers.
module mux_arb
    import lc3b_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              can_load;
    logic              sel_ok;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  sel_inc;
    logic              in_xfer;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        in_ready    = '0;

        can_load = !out_valid_q || out_ready;
        sel      = (state_q == ARB_LOCKED) ? grant_q : pick_idx;
        sel_ok   = (state_q == ARB_LOCKED) || pick_found;
        sel_inc  = (sel == SEL_W'(NUM_IN - 1)) ? '0 : sel + 1'b1;

        // rst_n gating keeps ready low for the whole reset window, not just after the first edge.
        if (rst_n && sel_ok && can_load) begin
            in_ready[sel] = 1'b1;
        end
        in_xfer = |(in_ready & in_valid);

        if (in_xfer) begin
            out_data_d  = in_data[sel*WIDTH +: WIDTH];
            out_sel_d   = sel;
            out_last_d  = in_last[sel];
            out_valid_d = 1'b1;
            if (in_last[sel]) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = sel_inc;
            end else begin
                state_d = ARB_LOCKED;
                grant_d = sel;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed vectors for mux_arb: a 4-source instance for fairness/burst/backpressure/stall and a 3-source instance for wrap.
module tb_mux_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [63:0] in_data4;
    logic [3:0]  in_valid4, in_last4, in_ready4;
    logic [15:0] out_data4;
    logic [1:0]  out_sel4;
    logic        out_last4, out_valid4, out_ready4;

    logic [47:0] in_data3;
    logic [2:0]  in_valid3, in_last3, in_ready3;
    logic [15:0] out_data3;
    logic [1:0]  out_sel3;
    logic        out_last3, out_valid3, out_ready3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_arb #(.WIDTH(16), .NUM_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_last(in_last4), .in_ready(in_ready4), .out_data(out_data4),
        .out_sel(out_sel4), .out_last(out_last4), .out_valid(out_valid4),
        .out_ready(out_ready4)
    );

    mux_arb #(.WIDTH(16), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
        .out_sel(out_sel3), .out_last(out_last3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        ordy;
        logic [15:0] d0;
        logic [15:0] d2;
        logic [3:0]  exp_ready;
        logic        exp_ovalid;
        logic [1:0]  exp_sel;
        logic [15:0] exp_data;
        logic        exp_olast;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic r,
                                input logic [15:0] d0, input logic [15:0] d2,
                                input logic [3:0] er, input logic eov, input logic [1:0] es,
                                input logic [15:0] ed, input logic eol);
        vec_t t;
        t.valid = v; t.last = l; t.ordy = r; t.d0 = d0; t.d2 = d2;
        t.exp_ready = er; t.exp_ovalid = eov; t.exp_sel = es; t.exp_data = ed; t.exp_olast = eol;
        return t;
    endfunction

    // Called at a negedge: drive, check ready, clock, check registered outputs, return to negedge.
    task automatic apply4(input int idx, input vec_t t);
        in_valid4  = t.valid;
        in_last4   = t.last;
        out_ready4 = t.ordy;
        in_data4   = {16'h1003, t.d2, 16'h1001, t.d0};
        #1;
        chk($sformatf("v%0d in_ready", idx), 64'(in_ready4), 64'(t.exp_ready));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", idx), 64'(out_valid4), 64'(t.exp_ovalid));
        chk($sformatf("v%0d out_sel", idx), 64'(out_sel4), 64'(t.exp_sel));
        chk($sformatf("v%0d out_data", idx), 64'(out_data4), 64'(t.exp_data));
        chk($sformatf("v%0d out_last", idx), 64'(out_last4), 64'(t.exp_olast));
        $display("v%0d valid=%b last=%b ordy=%b ready=%b -> ov=%b sel=%0d data=%h last=%b",
                 idx, t.valid, t.last, t.ordy, t.exp_ready, out_valid4, out_sel4, out_data4, out_last4);
        @(negedge clk);
    endtask

    initial begin
        // fairness: all valid, single-beat packets
        vecs[0]  = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'h1002, 4'b0001, 1, 0, 16'h1000, 1);
        vecs[1]  = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'h1002, 4'b0010, 1, 1, 16'h1001, 1);
        vecs[2]  = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'h1002, 4'b0100, 1, 2, 16'h1002, 1);
        vecs[3]  = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'h1002, 4'b1000, 1, 3, 16'h1003, 1);
        vecs[4]  = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'h1002, 4'b0001, 1, 0, 16'h1000, 1);
        vecs[5]  = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'h1002, 4'b0010, 1, 1, 16'h1001, 1);
        // burst from source 2 while everyone else is valid
        vecs[6]  = mk(4'b1111, 4'b1011, 1, 16'h1000, 16'hA001, 4'b0100, 1, 2, 16'hA001, 0);
        vecs[7]  = mk(4'b1111, 4'b1011, 1, 16'h1000, 16'hA002, 4'b0100, 1, 2, 16'hA002, 0);
        vecs[8]  = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'hA003, 4'b0100, 1, 2, 16'hA003, 1);
        vecs[9]  = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'h1002, 4'b1000, 1, 3, 16'h1003, 1);
        // backpressure holding 0x1234, then drain with no bubble
        vecs[10] = mk(4'b1111, 4'b1111, 1, 16'h1234, 16'h1002, 4'b0001, 1, 0, 16'h1234, 1);
        vecs[11] = mk(4'b1111, 4'b1111, 0, 16'h1000, 16'h1002, 4'b0000, 1, 0, 16'h1234, 1);
        vecs[12] = mk(4'b1111, 4'b1111, 0, 16'h1000, 16'h1002, 4'b0000, 1, 0, 16'h1234, 1);
        vecs[13] = mk(4'b1111, 4'b1111, 0, 16'h1000, 16'h1002, 4'b0000, 1, 0, 16'h1234, 1);
        vecs[14] = mk(4'b1111, 4'b1111, 0, 16'h1000, 16'h1002, 4'b0000, 1, 0, 16'h1234, 1);
        vecs[15] = mk(4'b1111, 4'b1111, 0, 16'h1000, 16'h1002, 4'b0000, 1, 0, 16'h1234, 1);
        vecs[16] = mk(4'b1111, 4'b1111, 1, 16'h1000, 16'h1002, 4'b0010, 1, 1, 16'h1001, 1);
        // idle: drain then nothing happens; pointer search wraps 2->3->0
        vecs[17] = mk(4'b0000, 4'b1111, 1, 16'h1000, 16'h1002, 4'b0000, 0, 1, 16'h1001, 1);
        vecs[18] = mk(4'b0000, 4'b1111, 0, 16'h1000, 16'h1002, 4'b0000, 0, 1, 16'h1001, 1);
        vecs[19] = mk(4'b0001, 4'b1111, 0, 16'h1000, 16'h1002, 4'b0001, 1, 0, 16'h1000, 1);
        // source 1 locks, stalls three cycles, resumes
        vecs[20] = mk(4'b1111, 4'b1101, 1, 16'h1000, 16'h1002, 4'b0010, 1, 1, 16'h1001, 0);
        vecs[21] = mk(4'b1101, 4'b1101, 1, 16'h1000, 16'h1002, 4'b0010, 0, 1, 16'h1001, 0);
        vecs[22] = mk(4'b1101, 4'b1101, 1, 16'h1000, 16'h1002, 4'b0010, 0, 1, 16'h1001, 0);
        vecs[23] = mk(4'b1101, 4'b1101, 1, 16'h1000, 16'h1002, 4'b0010, 0, 1, 16'h1001, 0);
        vecs[24] = mk(4'b1111, 4'b1101, 1, 16'h1000, 16'h1002, 4'b0010, 1, 1, 16'h1001, 0);

        in_valid4 = 4'b1111; in_last4 = 4'b1111; out_ready4 = 1'b1;
        in_data4  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        in_valid3 = 3'b000; in_last3 = 3'b111; out_ready3 = 1'b1;
        in_data3  = {16'h3002, 16'h3001, 16'h3000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid4), 64'd0);
        chk("reset in_ready", 64'(in_ready4), 64'd0);
        chk("reset out_data", 64'(out_data4), 64'd0);
        $display("reset held: out_valid=%b in_ready=%b", out_valid4, in_ready4);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            apply4(i, vecs[i]);
        end

        // reset in the middle of source 1's burst
        rst_n = 1'b0;
        #1;
        chk("midburst reset out_valid", 64'(out_valid4), 64'd0);
        chk("midburst reset in_ready", 64'(in_ready4), 64'd0);
        $display("midburst reset: out_valid=%b in_ready=%b", out_valid4, in_ready4);
        @(negedge clk);
        rst_n = 1'b1;
        apply4(25, mk(4'b1101, 4'b1111, 1, 16'h1000, 16'h1002, 4'b0001, 1, 0, 16'h1000, 1));

        // three sources, 0 and 2 valid: grants alternate and the pointer wraps 2->0
        in_valid3 = 3'b101;
        for (int i = 0; i < 6; i++) begin
            logic [2:0]  er;
            logic [1:0]  es;
            logic [15:0] ed;
            er = (i % 2 == 0) ? 3'b001 : 3'b100;
            es = (i % 2 == 0) ? 2'd0 : 2'd2;
            ed = (i % 2 == 0) ? 16'h3000 : 16'h3002;
            #1;
            chk($sformatf("n3 t%0d in_ready", i), 64'(in_ready3), 64'(er));
            @(posedge clk);
            #1;
            chk($sformatf("n3 t%0d out_sel", i), 64'(out_sel3), 64'(es));
            chk($sformatf("n3 t%0d out_data", i), 64'(out_data3), 64'(ed));
            chk($sformatf("n3 t%0d out_valid", i), 64'(out_valid3), 64'd1);
            $display("n3 t%0d ready=%b -> sel=%0d data=%h", i, in_ready3, out_sel3, out_data3);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
